// File: rtl/des_round_sequencer.sv
// des_round_sequencer: control FSM for an iterative DES core.
// Sequences IP load, ROUNDS Feistel rounds and the FP capture, and issues
// per-round C/D key rotation commands (left for encrypt, right for decrypt).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start_valid/ready   : block request handshake, decrypt_in sampled on it
//   abort               : drop the current block, return to idle
//   dp_load/round_en/final : datapath strobes (mutually exclusive)
//   round_idx, key_shift, key_dir : round number and key rotate command
//   busy, out_valid/out_ready : status and result handshake
module des_round_sequencer #(
    parameter int          ROUNDS     = 16,
    parameter logic [15:0] ENC_SHIFT2 = 16'h7EFC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       decrypt_in,
    input  logic       abort,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic [3:0] round_idx,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic       dp_final,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       mode, mode_nx;
    logic [4:0] dec_idx;

    // Decrypt walks the encrypt schedule backwards, one round behind:
    // round r undoes the rotation encrypt applied in round ROUNDS-r.
    assign dec_idx = 5'(ROUNDS) - {1'b0, cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            mode  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            mode  <= mode_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        mode_nx     = mode;
        start_ready = 1'b0;
        dp_load     = 1'b0;
        dp_round_en = 1'b0;
        dp_final    = 1'b0;
        round_idx   = 4'd0;
        key_shift   = 2'd0;
        key_dir     = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;

        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    mode_nx  = decrypt_in;
                    state_nx = S_LOAD;
                end
            end

            S_LOAD: begin
                busy     = 1'b1;
                dp_load  = 1'b1;
                cnt_nx   = 4'd0;
                state_nx = abort ? S_IDLE : S_ROUND;
            end

            S_ROUND: begin
                busy        = 1'b1;
                dp_round_en = 1'b1;
                round_idx   = cnt;
                key_dir     = mode;
                if (!mode)
                    key_shift = ENC_SHIFT2[cnt] ? 2'd2 : 2'd1;
                else if (cnt != 4'd0)
                    key_shift = ENC_SHIFT2[dec_idx[3:0]] ? 2'd2 : 2'd1;
                if (abort) begin
                    cnt_nx   = 4'd0;
                    state_nx = S_IDLE;
                end else if (cnt == LAST) begin
                    cnt_nx   = 4'd0;
                    state_nx = S_FINAL;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end

            S_FINAL: begin
                busy = 1'b1;
                // An aborted block must never reach the output register.
                dp_final = !abort;
                state_nx = abort ? S_IDLE : S_DONE;
            end

            S_DONE: begin
                out_valid   = 1'b1;
                start_ready = out_ready && !abort;
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (out_ready) begin
                    if (start_valid) begin
                        mode_nx  = decrypt_in;
                        state_nx = S_LOAD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end

            default: begin
                cnt_nx   = 4'd0;
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: self-checking bench for des_round_sequencer.
// A block-timeline model predicts every output from cycles since start.
module tb_des_round_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic       decrypt_in;
    logic       abort;
    logic       dp_load;
    logic       dp_round_en;
    logic [3:0] round_idx;
    logic [1:0] key_shift;
    logic       key_dir;
    logic       dp_final;
    logic       busy;
    logic       out_valid;
    logic       out_ready;

    int errors = 0;
    int checks = 0;

    // Standard DES key schedule: left shifts per encrypt round.
    localparam int SCHED[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always #5 clk = ~clk;

    des_round_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .decrypt_in (decrypt_in),
        .abort      (abort),
        .dp_load    (dp_load),
        .dp_round_en(dp_round_en),
        .round_idx  (round_idx),
        .key_shift  (key_shift),
        .key_dir    (key_dir),
        .dp_final   (dp_final),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    logic [12:0] obs;
    assign obs = {dp_load, dp_round_en, dp_final, busy, out_valid,
                  start_ready, round_idx, key_shift, key_dir};

    // t = cycles since the accepted start (<=0 idle, 1 load,
    // 2..17 rounds, 18 final, >=19 result held).
    function automatic logic [12:0] model(int t, bit m, bit ordy, bit abrt);
        logic       ld, re, fi, bz, ov, sr, kd;
        logic [3:0] ri;
        logic [1:0] ks;
        int         r;
        {ld, re, fi, bz, ov, sr, kd} = '0;
        ri = 4'd0;
        ks = 2'd0;
        if (t <= 0) begin
            sr = 1'b1;
        end else if (t == 1) begin
            ld = 1'b1;
            bz = 1'b1;
        end else if (t <= 17) begin
            r  = t - 2;
            re = 1'b1;
            bz = 1'b1;
            ri = 4'(r);
            kd = m;
            if (!m)
                ks = 2'(SCHED[r]);
            else if (r != 0)
                ks = 2'(SCHED[16 - r]);
        end else if (t == 18) begin
            fi = !abrt;
            bz = 1'b1;
        end else begin
            ov = 1'b1;
            sr = ordy && !abrt;
        end
        return {ld, re, fi, bz, ov, sr, ri, ks, kd};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b0;
        decrypt_in = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        repeat (3) cyc();
        #1;
        checks++;
        if (obs !== model(-1, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", obs, model(-1, 0, 0, 0));
        end
        rst = 1'b0;
        cyc();
        #1;
        checks++;
        if (obs !== model(-1, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs, model(-1, 0, 0, 0));
        end
        cyc();
    endtask

    task automatic test_mode(bit m);
        int sum = 0;
        start_valid = 1'b1;
        decrypt_in = m;
        #1;
        checks++;
        if (obs !== model(0, m, 0, 0)) begin
            errors++;
            $display("FAIL mode%0d_start got %h want %h", m, obs, model(0, m, 0, 0));
        end
        cyc();
        start_valid = 1'b0;
        decrypt_in = !m;
        for (int t = 1; t <= 19; t++) begin
            #1;
            checks++;
            if (obs !== model(t, m, 0, 0)) begin
                errors++;
                $display("FAIL mode%0d_t%0d got %h want %h", m, t, obs, model(t, m, 0, 0));
            end
            if (dp_round_en)
                sum += int'(key_shift);
            cyc();
        end
        checks++;
        if (sum !== (m ? 27 : 28)) begin
            errors++;
            $display("FAIL mode%0d_shift_sum got %0d want %0d", m, sum, m ? 27 : 28);
        end
        retire();
    endtask

    task automatic test_backpressure();
        int gap = 0;
        start_valid = 1'b1;
        decrypt_in = 1'b0;
        cyc();
        start_valid = 1'b0;
        repeat (18) cyc();
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (obs !== model(19 + k, 0, 0, 0)) begin
                errors++;
                $display("FAIL hold_%0d got %h want %h", k, obs, model(19 + k, 0, 0, 0));
            end
            if (k < 5) cyc();
        end
        out_ready = 1'b1;
        start_valid = 1'b1;
        decrypt_in = 1'b1;
        #1;
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release start_ready got %b want 1", start_ready);
        end
        cyc();
        out_ready = 1'b0;
        start_valid = 1'b0;
        decrypt_in = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            #1;
            if (t <= 19) begin
                checks++;
                if (obs !== model(t, 1, 0, 0)) begin
                    errors++;
                    $display("FAIL b2b_dec_t%0d got %h want %h", t, obs, model(t, 1, 0, 0));
                end
            end
            if (out_valid) begin
                gap = t;
                break;
            end
            cyc();
        end
        checks++;
        if (gap !== 19) begin
            errors++;
            $display("FAIL handshake_to_valid got %0d want 19", gap);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        int  t = 0;
        bit  m = 0, m_next = 0;
        int  rises[$];
        bit  prev = 0;
        out_ready = 1'b1;
        for (int n = 0; n <= 57; n++) begin
            start_valid = (n < 57);
            decrypt_in = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== model(t, m, 1, 0)) begin
                errors++;
                $display("FAIL stream_n%0d got %h want %h", n, obs, model(t, m, 1, 0));
            end
            if (out_valid && !prev) rises.push_back(n);
            prev = out_valid;
            m_next = decrypt_in;
            cyc();
            if ((t == 0 || t == 19) && n < 57) begin
                m = m_next;
                t = 1;
            end else begin
                t = t + 1;
            end
        end
        start_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (rises.size() != 3 || rises[1] - rises[0] != 19 || rises[2] - rises[1] != 19) begin
            errors++;
            $display("FAIL stream_period rises=%0d want 3 at period 19", rises.size());
        end
    endtask

    task automatic test_abort();
        int seen = 0, lat = 0;
        start_valid = 1'b1;
        decrypt_in = 1'b0;
        cyc();
        start_valid = 1'b0;
        repeat (8) cyc();
        abort = 1'b1;
        #1;
        checks++;
        if (obs !== model(9, 0, 0, 1)) begin
            errors++;
            $display("FAIL abort_cycle got %h want %h", obs, model(9, 0, 0, 1));
        end
        cyc();
        abort = 1'b0;
        #1;
        checks++;
        if (obs !== model(-1, 0, 0, 0)) begin
            errors++;
            $display("FAIL abort_idle got %h want %h", obs, model(-1, 0, 0, 0));
        end
        for (int k = 0; k < 20; k++) begin
            if (dp_final || out_valid || dp_round_en) seen++;
            cyc();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_leak got %0d strobes want 0", seen);
        end
        start_valid = 1'b1;
        cyc();
        start_valid = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            #1;
            if (out_valid) begin
                lat = t;
                break;
            end
            cyc();
        end
        checks++;
        if (lat !== 19) begin
            errors++;
            $display("FAIL abort_restart_latency got %0d want 19", lat);
        end
        retire();
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c < 3; c++) begin
            start_valid = 1'b1;
            decrypt_in = 1'b1;
            cyc();
            start_valid = 1'b0;
            repeat (c == 0 ? 6 : 19) cyc();
            if (c == 2) begin
                abort = 1'b1;
                start_valid = 1'b1;
                out_ready = 1'b1;
            end else begin
                rst = 1'b1;
            end
            cyc();
            rst = 1'b0;
            abort = 1'b0;
            start_valid = 1'b0;
            out_ready = 1'b0;
            #1;
            checks++;
            if (obs !== model(-1, 0, 0, 0)) begin
                errors++;
                $display("FAIL rst_abort_case%0d got %h want %h", c, obs, model(-1, 0, 0, 0));
            end
            cyc();
            #1;
            checks++;
            if (obs !== model(-1, 0, 0, 0)) begin
                errors++;
                $display("FAIL rst_abort_case%0d_next got %h want %h", c, obs, model(-1, 0, 0, 0));
            end
            cyc();
        end
    endtask

    task automatic test_random();
        int t = -1;
        bit m = 0;
        for (int n = 0; n < 600; n++) begin
            start_valid = ($urandom_range(0, 3) != 0);
            decrypt_in = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            abort = ($urandom_range(0, 49) == 0);
            #1;
            checks++;
            if (obs !== model(t, m, out_ready, abort)) begin
                errors++;
                $display("FAIL random_n%0d t%0d got %h want %h", n, t, obs,
                         model(t, m, out_ready, abort));
            end
            if (t <= 0) begin
                if (start_valid) begin
                    m = decrypt_in;
                    t = 1;
                end
            end else if (abort) begin
                t = -1;
            end else if (t < 19) begin
                t = t + 1;
            end else if (out_ready) begin
                if (start_valid) begin
                    m = decrypt_in;
                    t = 1;
                end else begin
                    t = -1;
                end
            end
            cyc();
        end
        start_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode(1'b0);
        test_mode(1'b1);
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
